rest_div_n: RTL
===============

// Module: rest_div_n
// PURPOSE
//  Parametrised sequential restoring divider, successor to the 4-bit unsigned divider.
//  Computes quotient and remainder of W-bit operands at one quotient bit per cycle.
//  Adds signed/unsigned mode per operation, divide-by-zero and overflow flags, and
//  valid/ready handshakes on both sides for use as a shared datapath arithmetic unit.
// PARAMETERS
//  W      8   operand/result width; legal W >= 2
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  reset, asynchronous, active-low
//  flush       in   1  synchronous abort: discard the in-flight op and return to IDLE
//  in_valid    in   1  operands valid
//  in_ready    out  1  divider can accept (high only in IDLE)
//  in_signed   in   1  1 = two's-complement op, 0 = unsigned; sampled at accept
//  dividend    in   W  dividend, sampled at accept
//  divisor     in   W  divisor, sampled at accept
//  out_valid   out  1  result valid; held until out_ready
//  out_ready   in   1  consumer accepts result
//  quot        out  W  quotient
//  rem         out  W  remainder
//  dbz         out  1  divide-by-zero flag, qualified by out_valid
//  ovf         out  1  signed overflow flag, qualified by out_valid
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: state = IDLE; in_ready = 1; out_valid = busy = dbz = ovf = 0; quot = rem = 0.
//  Accept: in_valid & in_ready at a rising edge. Latch the operand magnitudes
//    (|x| in signed mode, raw value otherwise), the mode, the sign of the dividend and
//    the quotient sign (dividend sign XOR divisor sign). Load count = 0.
//  States:
//    IDLE -> ITER on accept with divisor != 0; IDLE -> DONE on accept with divisor == 0.
//    ITER: W cycles. Each cycle:
//      - shift {R, Q} left by 1 (R is W+1 bits);
//      - T = R - D;
//      - if T is negative, keep R (restore) and set Q[0] = 0; else R = T and Q[0] = 1.
//      - count++; on count == W-1, go to FIX.
//    FIX: 1 cycle.
//      - quot = quotient-sign ? -Q : Q.
//      - rem = dividend-sign ? -R[W-1:0] : R[W-1:0].
//      - Unsigned mode applies no negation.
//      - Go to DONE.
//    DONE: out_valid = 1. On out_ready, go to IDLE.
//  Latency: out_valid rises W+2 cycles after the accept edge (10 for W=8). With
//    divisor == 0, out_valid rises 1 cycle after accept.
//  Divide by zero: quot = all ones, rem = dividend (raw), dbz = 1, ovf = 0.
//  Signed overflow: dividend = most-negative value and divisor = -1.
//    quot = most-negative value (wraps), rem = 0, ovf = 1.
//  Signed semantics: truncation toward zero; remainder carries the dividend sign.
//    Magnitude |most-negative| is held as unsigned W-bit 2^(W-1).
//  Handshake rules:
//    - in_ready is 0 from the accept edge until the out handshake completes.
//    - New operands are never accepted in the cycle out_valid drops (that cycle is
//      IDLE, in_ready = 1, so the next accept occurs at the earliest one edge later).
//    - quot, rem, dbz and ovf are stable while out_valid = 1 and out_ready = 0.
//  flush: forces IDLE next edge from any state, clears out_valid and flags, and drops
//    a pending result. flush has priority over accept in the same cycle.
//  Reset mid-operation: immediate return to reset values; no result is produced.
// STRUCTURE
//  Package rest_div_pkg:
//    - state encodings IDLE/ITER/FIX/DONE (2-bit localparams);
//    - function for the counter width, $clog2(W), minimum 1.
//  Sub-module rest_div_step:
//    - combinational single iteration: {R, Q}, D -> next {R, Q};
//    - parametrised by W;
//    - instantiated once; the FSM, counter and handshake stay in rest_div_n.
// TESTING (W=8)
//  1. Unsigned 100 / 7 -> quot = 14, rem = 2, flags 0; out_valid exactly 10 cycles after accept.
//  2. Signed -100 / 7 (0x9C / 0x07) -> quot = 0xF2 (-14), rem = 0xFE (-2); 100 / -7 -> 0xF2, 0x02.
//  3. 5 / 0, either mode -> dbz = 1, quot = 0xFF, rem = 0x05; out_valid 1 cycle after accept.
//  4. Signed 0x80 / 0xFF -> ovf = 1, quot = 0x80, rem = 0x00. The same operands
//     unsigned (128 / 255) -> quot = 0, rem = 128, ovf = 0.
//  5. Backpressure: out_ready low for 5 cycles in DONE -> outputs held, in_ready = 0;
//     in_valid held high -> the next op is accepted only after the out handshake.
//  6. flush at ITER cycle 3, then rst low at ITER cycle 4 of a later op -> no out_valid,
//     reset values restored, and the next 255 / 16 unsigned op -> quot = 15, rem = 15.

Source files
------------

// File: rtl/rest_div_pkg.sv
// ---------------------------------------------------------------------------
// rest_div_pkg : shared state encodings and sizing helper for rest_div_n
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rest_div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Iteration counter must reach W-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rest_div_step.sv
// ---------------------------------------------------------------------------
// rest_div_step : one restoring-division iteration, {R,Q},D -> next {R,Q}
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rest_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   r_in,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] d_in,
  output logic [W:0]   r_out,
  output logic [W-1:0] q_out
);

  logic [2*W:0] shifted;
  logic [W:0]   r_sh;
  logic [W+1:0] trial;
  logic         trial_neg;

  always_comb begin
    shifted   = {r_in, q_in} << 1;
    r_sh      = shifted[2*W:W];
    // One extra bit so a negative trial difference shows up as its MSB.
    trial     = {1'b0, r_sh} - {2'b00, d_in};
    trial_neg = trial[W+1];
    r_out     = trial_neg ? r_sh : trial[W:0];
    q_out     = shifted[W-1:0] | {{(W-1){1'b0}}, ~trial_neg};
  end

endmodule

`default_nettype wire

// File: rtl/rest_div_n.sv
// ---------------------------------------------------------------------------
// rest_div_n : sequential signed/unsigned restoring divider with handshakes
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rest_div_n
  import rest_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         dbz,
  output logic         ovf,
  output logic         busy
);

  localparam int          CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  q_q, q_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dsign_q, dsign_d, qsign_q, qsign_d;
  logic          out_valid_q, out_valid_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;

  logic [W:0]    r_step;
  logic [W-1:0]  q_step;
  logic          accept, div_zero, dvd_neg, dvs_neg;
  logic [W-1:0]  dvd_mag, dvs_mag;

  rest_div_step #(.W(W)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (r_step),
    .q_out (q_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dsign_q     <= 1'b0;
      qsign_q     <= 1'b0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dsign_q     <= dsign_d;
      qsign_q     <= qsign_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = div_zero ? DONE : ITER;
        ITER:    if (cnt_q == CNT_LAST) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (out_valid_q && out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    quot      = quot_q;
    rem       = rem_q;
    dbz       = dbz_q;
    ovf       = ovf_q;
  end

  // Operand magnitudes; -MOST_NEG wraps to 2^(W-1), which is the right unsigned magnitude.
  always_comb begin
    accept   = in_valid && (state_q == IDLE) && !flush;
    div_zero = (divisor == '0);
    dvd_neg  = in_signed && dividend[W-1];
    dvs_neg  = in_signed && divisor[W-1];
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dvs_mag  = dvs_neg ? -divisor : divisor;
  end

  always_comb begin
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dsign_d     = dsign_q;
    qsign_d     = qsign_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    if (flush) begin
      out_valid_d = 1'b0;
      dbz_d       = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            r_d     = '0;
            q_d     = dvd_mag;
            d_d     = dvs_mag;
            cnt_d   = '0;
            dsign_d = dvd_neg;
            qsign_d = dvd_neg ^ dvs_neg;
            dbz_d   = div_zero;
            ovf_d   = in_signed && (dividend == MOST_NEG) && (divisor == '1);
            if (div_zero) begin
              quot_d = '1;
              rem_d  = dividend;
            end
          end
        end
        ITER: begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q + 1'b1;
        end
        FIX: begin
          quot_d = qsign_q ? -q_q : q_q;
          rem_d  = dsign_q ? -r_q[W-1:0] : r_q[W-1:0];
        end
        DONE: begin
          // Registered one cycle behind the state; drops with the out handshake.
          out_valid_d = !(out_valid_q && out_ready);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
